// File: rtl/fft_state3.sv
// fft_state3: third radix-2 DIF stage of the 32-point MDC FFT (delay/commutator/delay, butterfly, W8 twiddle).
// Build option: define FFT_STATE3_SAT_EN to saturate the scaled outputs instead of wrapping them.
module fft_state3 #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_l_re,
  input  logic signed [WIDTH-1:0] in_l_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_up_re,
  output logic signed [WIDTH-1:0] out_up_im,
  output logic signed [WIDTH-1:0] out_l_re,
  output logic signed [WIDTH-1:0] out_l_im
);

  localparam int SELB      = $clog2(DEPTH);
  localparam int CW        = SELB + 1;
  localparam int PRIME_MAX = 2 * DEPTH;
  localparam int PW        = $clog2(PRIME_MAX + 1);
  localparam int DW        = WIDTH + 1;
  localparam int TW        = 9;
  localparam int MW        = DW + TW + 1;
  localparam int LW        = DEPTH * WIDTH;

  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  // Delay lines are packed shift registers; the oldest sample sits in the top slice.
  logic [LW-1:0] ldRe_q, ldIm_q, udRe_q, udIm_q;
  logic [LW-1:0] ldRe_d, ldIm_d, udRe_d, udIm_d;

  logic [CW-1:0] cnt_q, cnt_d, cntEff;
  logic [PW-1:0] prime_q, prime_d, primeEff;
  logic          valid_q, valid_d;

  logic signed [WIDTH-1:0] upRe_q, upIm_q, lRe_q, lIm_q;
  logic signed [WIDTH-1:0] upRe_d, upIm_d, lRe_d, lIm_d;

  logic signed [WIDTH-1:0] ldReOld, ldImOld, udReOld, udImOld;
  logic signed [WIDTH-1:0] cuRe, cuIm, clRe, clIm;
  logic signed [DW-1:0]    sumRe, sumIm, diffRe, diffIm;
  logic signed [TW-1:0]    wRe, wIm;
  logic signed [MW-1:0]    prodRe, prodIm;
  logic                    unusedBits;

  assign ldReOld = ldRe_q[LW-1 -: WIDTH];
  assign ldImOld = ldIm_q[LW-1 -: WIDTH];
  assign udReOld = udRe_q[LW-1 -: WIDTH];
  assign udImOld = udIm_q[LW-1 -: WIDTH];

  always_comb begin
    // A start-of-frame sample behaves as cnt=0 with an empty prime count.
    cntEff   = in_sof ? '0 : cnt_q;
    primeEff = in_sof ? '0 : prime_q;
    cnt_d    = cntEff + 1'b1;
    valid_d  = (primeEff == PW'(PRIME_MAX));
    prime_d  = valid_d ? primeEff : primeEff + 1'b1;

    cuRe = in_up_re;
    cuIm = in_up_im;
    clRe = ldReOld;
    clIm = ldImOld;
    if (cntEff[SELB]) begin
      cuRe = ldReOld;
      cuIm = ldImOld;
      clRe = in_up_re;
      clIm = in_up_im;
    end

    ldRe_d = {ldRe_q[LW-WIDTH-1:0], in_l_re};
    ldIm_d = {ldIm_q[LW-WIDTH-1:0], in_l_im};
    udRe_d = {udRe_q[LW-WIDTH-1:0], cuRe};
    udIm_d = {udIm_q[LW-WIDTH-1:0], cuIm};

    sumRe  = {udReOld[WIDTH-1], udReOld} + {clRe[WIDTH-1], clRe};
    sumIm  = {udImOld[WIDTH-1], udImOld} + {clIm[WIDTH-1], clIm};
    diffRe = {udReOld[WIDTH-1], udReOld} - {clRe[WIDTH-1], clRe};
    diffIm = {udImOld[WIDTH-1], udImOld} - {clIm[WIDTH-1], clIm};

    wRe = 9'sd128;
    wIm = 9'sd0;
    case (cntEff[1:0])
      2'd1:    begin wRe = 9'sd91;  wIm = -9'sd91;  end
      2'd2:    begin wRe = 9'sd0;   wIm = -9'sd128; end
      2'd3:    begin wRe = -9'sd91; wIm = -9'sd91;  end
      default: ;
    endcase

    prodRe = MW'(diffRe) * MW'(wRe) - MW'(diffIm) * MW'(wIm);
    prodIm = MW'(diffRe) * MW'(wIm) + MW'(diffIm) * MW'(wRe);

    // The halved sum of two WIDTH-bit values always fits, so only the twiddled path can overflow.
    upRe_d = sumRe[WIDTH:1];
    upIm_d = sumIm[WIDTH:1];
`ifdef FFT_STATE3_SAT_EN
    if (&prodRe[MW-1:WIDTH+7] || !(|prodRe[MW-1:WIDTH+7])) lRe_d = prodRe[WIDTH+7:8];
    else lRe_d = prodRe[MW-1] ? MINV : MAXV;
    if (&prodIm[MW-1:WIDTH+7] || !(|prodIm[MW-1:WIDTH+7])) lIm_d = prodIm[WIDTH+7:8];
    else lIm_d = prodIm[MW-1] ? MINV : MAXV;
`else
    lRe_d = prodRe[WIDTH+7:8];
    lIm_d = prodIm[WIDTH+7:8];
`endif
  end

  assign unusedBits = ^{sumRe[0], sumIm[0], prodRe, prodIm, MAXV, MINV};

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ldRe_q  <= '0;
      ldIm_q  <= '0;
      udRe_q  <= '0;
      udIm_q  <= '0;
      cnt_q   <= '0;
      prime_q <= '0;
      valid_q <= 1'b0;
      upRe_q  <= '0;
      upIm_q  <= '0;
      lRe_q   <= '0;
      lIm_q   <= '0;
    end else if (in_valid) begin
      ldRe_q  <= ldRe_d;
      ldIm_q  <= ldIm_d;
      udRe_q  <= udRe_d;
      udIm_q  <= udIm_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      valid_q <= valid_d;
      upRe_q  <= upRe_d;
      upIm_q  <= upIm_d;
      lRe_q   <= lRe_d;
      lIm_q   <= lIm_d;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_up_re = upRe_q;
  assign out_up_im = upIm_q;
  assign out_l_re  = lRe_q;
  assign out_l_im  = lIm_q;

endmodule

// File: tb/tb_fft_state3.sv
// Self-checking bench for fft_state3: directed and random stimulus against a sample-history reference model.
`timescale 1ns/1ps
module tb_fft_state3;

  localparam int W = 10;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_sof = 1'b0;
  logic signed [W-1:0] in_up_re = '0, in_up_im = '0, in_l_re = '0, in_l_im = '0;
  logic                out_valid;
  logic signed [W-1:0] out_up_re, out_up_im, out_l_re, out_l_im;
  logic [4*W:0]        dutVec;

  int vectors = 0;
  int miscompares = 0;

  fft_state3 #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_up_re(in_up_re), .in_up_im(in_up_im), .in_l_re(in_l_re), .in_l_im(in_l_im),
    .out_valid(out_valid), .out_up_re(out_up_re), .out_up_im(out_up_im),
    .out_l_re(out_l_re), .out_l_im(out_l_im)
  );

  always #5 clk = ~clk;

  assign dutVec = {out_valid, out_up_re, out_up_im, out_l_re, out_l_im};

  // Reference model: full history of accepted samples since reset, indexed by arithmetic.
  int histLRe[$], histLIm[$], histCuRe[$], histCuIm[$];
  int mCnt = 0, mPrime = 0;
  bit mValid = 1'b0;
  int mUpRe = 0, mUpIm = 0, mLRe = 0, mLIm = 0;
  int wrTab[4] = '{128, 91, 0, -91};
  int wiTab[4] = '{0, -91, -128, -91};

  function automatic int fitW(input int v);
    int w;
`ifdef FFT_STATE3_SAT_EN
    w = v;
    if (v > 511) w = 511;
    if (v < -512) w = -512;
`else
    w = v & 1023;
    if (w >= 512) w = w - 1024;
`endif
    return w;
  endfunction

  function automatic void modelStep();
    int a, c, p, ldRe, ldIm, udRe, udIm, uRe, uIm, cuRe, cuIm, clRe, clIm, dr, di, k, pr, pim;
    if (rst_n) begin
      histLRe.delete(); histLIm.delete(); histCuRe.delete(); histCuIm.delete();
      mCnt = 0; mPrime = 0; mValid = 1'b0;
      mUpRe = 0; mUpIm = 0; mLRe = 0; mLIm = 0;
      return;
    end
    if (!in_valid) begin
      mValid = 1'b0;
      return;
    end
    c = in_sof ? 0 : mCnt;
    p = in_sof ? 0 : mPrime;
    a = histLRe.size();
    ldRe = (a >= 4) ? histLRe[a-4] : 0;
    ldIm = (a >= 4) ? histLIm[a-4] : 0;
    udRe = (a >= 4) ? histCuRe[a-4] : 0;
    udIm = (a >= 4) ? histCuIm[a-4] : 0;
    uRe = in_up_re;
    uIm = in_up_im;
    if (c >= 4) begin
      cuRe = ldRe; cuIm = ldIm; clRe = uRe; clIm = uIm;
    end else begin
      cuRe = uRe; cuIm = uIm; clRe = ldRe; clIm = ldIm;
    end
    histLRe.push_back(int'(in_l_re));
    histLIm.push_back(int'(in_l_im));
    histCuRe.push_back(cuRe);
    histCuIm.push_back(cuIm);
    mUpRe = fitW((udRe + clRe) >>> 1);
    mUpIm = fitW((udIm + clIm) >>> 1);
    dr = udRe - clRe;
    di = udIm - clIm;
    k = c % 4;
    pr = dr * wrTab[k] - di * wiTab[k];
    pim = dr * wiTab[k] + di * wrTab[k];
    mLRe = fitW(pr >>> 8);
    mLIm = fitW(pim >>> 8);
    mValid = (p == 8);
    mCnt = (c + 1) % 8;
    mPrime = (p < 8) ? p + 1 : 8;
  endfunction

  function automatic logic [4*W:0] expVec();
    logic [W-1:0] a, b, c, d;
    a = mUpRe[W-1:0];
    b = mUpIm[W-1:0];
    c = mLRe[W-1:0];
    d = mLIm[W-1:0];
    return {mValid, a, b, c, d};
  endfunction

  function automatic int rnd();
    int r;
    r = int'($urandom_range(3));
    if (r == 0) return (int'($urandom_range(1)) == 0) ? 511 : -512;
    return int'($urandom_range(1023)) - 512;
  endfunction

  task automatic drive(input bit rst, input bit vld, input bit sof,
                       input int ur, input int ui, input int lr, input int li);
    @(negedge clk);
    rst_n    = rst;
    in_valid = vld;
    in_sof   = sof;
    in_up_re = W'(ur);
    in_up_im = W'(ui);
    in_l_re  = W'(lr);
    in_l_im  = W'(li);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)), rnd(), rnd(), rnd(), rnd());
      vectors++;
      if (dutVec !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_zero cyc %0d got %h expected 0", i, dutVec);
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
      vectors++;
      if (out_valid !== 1'b0 || dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL reset_unprimed cyc %0d got %h expected %h", i, dutVec, expVec());
      end
    end
  endtask

  task automatic test_dc();
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      drive(1'b0, 1'b1, 1'(n == 0), 10, 0, 10, 0);
      vectors++;
      if (dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL dc_model n %0d got %h expected %h", n, dutVec, expVec());
      end
      if (n >= 8) begin
        vectors++;
        if ({out_valid, out_up_re, out_l_re, out_l_im} !== {1'b1, 10'sd10, 10'sd0, 10'sd0}) begin
          miscompares++;
          $display("[TB] FAIL dc_value n %0d got v=%0b up=%0d l=(%0d,%0d) expected v=1 up=10 l=(0,0)",
                   n, out_valid, out_up_re, out_l_re, out_l_im);
        end
      end
    end
  endtask

  int twRe[4] = '{32, 22, 0, -23};
  int twIm[4] = '{0, -23, -32, -23};

  task automatic test_twiddle();
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      drive(1'b0, 1'b1, 1'(n == 0), ((n % 8) < 4) ? 64 : 0, 0, 0, 0);
      vectors++;
      if (dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL twiddle_model n %0d got %h expected %h", n, dutVec, expVec());
      end
      if (n >= 12) begin
        vectors++;
        if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !==
            {1'b1, 10'sd32, 10'sd0, W'(twRe[n-12]), W'(twIm[n-12])}) begin
          miscompares++;
          $display("[TB] FAIL twiddle_value n %0d got up=%0d l=(%0d,%0d) expected up=32 l=(%0d,%0d)",
                   n, out_up_re, out_l_re, out_l_im, twRe[n-12], twIm[n-12]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int n;
    n = 0;
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int cyc = 0; cyc < 40 && n < 16; cyc++) begin
      if (cyc % 2 == 1) begin
        drive(1'b0, 1'b0, 1'($urandom_range(1)), rnd(), rnd(), rnd(), rnd());
        vectors++;
        if (out_valid !== 1'b0 || dutVec !== expVec()) begin
          miscompares++;
          $display("[TB] FAIL stall_bubble cyc %0d got %h expected %h", cyc, dutVec, expVec());
        end
      end else begin
        drive(1'b0, 1'b1, 1'(n == 0), ((n % 8) < 4) ? 64 : 0, 0, 0, 0);
        vectors++;
        if (dutVec !== expVec()) begin
          miscompares++;
          $display("[TB] FAIL stall_model n %0d got %h expected %h", n, dutVec, expVec());
        end
        if (n >= 12) begin
          vectors++;
          if ({out_valid, out_up_re, out_l_re, out_l_im} !==
              {1'b1, 10'sd32, W'(twRe[n-12]), W'(twIm[n-12])}) begin
            miscompares++;
            $display("[TB] FAIL stall_value n %0d got up=%0d l=(%0d,%0d) expected up=32 l=(%0d,%0d)",
                     n, out_up_re, out_l_re, out_l_im, twRe[n-12], twIm[n-12]);
          end
        end
        n++;
      end
    end
  endtask

  task automatic test_sof_resync();
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n < 36; n++) begin
      drive(1'b0, 1'b1, 1'(n == 0 || n == 13), rnd(), rnd(), rnd(), rnd());
      vectors++;
      if (dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL sof_model n %0d got %h expected %h", n, dutVec, expVec());
      end
      if (n >= 12 && n <= 21) begin
        vectors++;
        if (out_valid !== 1'(n == 12 || n == 21)) begin
          miscompares++;
          $display("[TB] FAIL sof_valid n %0d got %0b expected %0b", n, out_valid, (n == 12 || n == 21));
        end
      end
    end
  endtask

  task automatic test_overflow();
    int v, expRe13, expIm15;
`ifdef FFT_STATE3_SAT_EN
    expRe13 = 511;
    expIm15 = -512;
`else
    expRe13 = -297;
    expIm15 = 296;
`endif
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
    for (int n = 0; n < 24; n++) begin
      v = ((n % 8) < 4) ? 511 : -512;
      drive(1'b0, 1'b1, 1'(n == 0), v, v, -512, -512);
      vectors++;
      if (dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL ovf_model n %0d got %h expected %h", n, dutVec, expVec());
      end
      if (n == 12 || n == 20) begin
        vectors++;
        if ({out_l_re, out_l_im} !== {10'sd511, 10'sd511}) begin
          miscompares++;
          $display("[TB] FAIL ovf_k0 n %0d got (%0d,%0d) expected (511,511)", n, out_l_re, out_l_im);
        end
      end
      if (n == 13) begin
        vectors++;
        if ({out_l_re, out_l_im} !== {W'(expRe13), 10'sd0}) begin
          miscompares++;
          $display("[TB] FAIL ovf_k1 got (%0d,%0d) expected (%0d,0)", out_l_re, out_l_im, expRe13);
        end
      end
      if (n == 15) begin
        vectors++;
        if ({out_l_re, out_l_im} !== {10'sd0, W'(expIm15)}) begin
          miscompares++;
          $display("[TB] FAIL ovf_k3 got (%0d,%0d) expected (0,%0d)", out_l_re, out_l_im, expIm15);
        end
      end
    end
  endtask

  task automatic test_random();
    bit rst, vld, sof;
    for (int i = 0; i < 1500; i++) begin
      rst = (int'($urandom_range(99)) == 0);
      vld = (int'($urandom_range(3)) != 0);
      sof = (int'($urandom_range(29)) == 0);
      drive(rst, vld, sof, rnd(), rnd(), rnd(), rnd());
      vectors++;
      if (dutVec !== expVec()) begin
        miscompares++;
        $display("[TB] FAIL random cyc %0d got %h expected %h", i, dutVec, expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_twiddle();
    test_stall();
    test_sof_resync();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/fft_state3.md
Name: fft_state3

Overview:
- Third radix-2 DIF stage of the 32-point MDC FFT. Sits directly downstream of fft_state2 and consumes its two parallel streams (upper and lower).
- Reorders the stream pair with a delay-4 / commutator / delay-4 network, then runs a butterfly. The lower butterfly output is multiplied by a W8 twiddle from an internal 4-entry ROM.
- Unlike state2, the block generates its own commutator select and twiddle index from an internal sample counter. It also provides valid / start-of-frame handshaking.

Parameters:
- WIDTH, 10, bit width of every data input and output (signed two's complement).
- DEPTH, 4, delay-line length in samples. Must be a power of two; commutator select is counter bit log2(DEPTH).

Ports:
- clk  input  1  clock. Single clock domain; all state updates on the rising edge.
- rst_n  input  1  reset. Synchronous and active-high: asserted (1) at a rising edge, it resets the block. The codebase port name is kept.
- in_valid  input  1  input pair valid this cycle.
- in_sof  input  1  first sample of a frame; qualified by in_valid.
- in_up_re, in_up_im  input  WIDTH  upper stream from state2.
- in_l_re, in_l_im  input  WIDTH  lower stream from state2.
- out_valid  output  1  output pair valid.
- out_up_re, out_up_im  output  WIDTH  butterfly sum, scaled.
- out_l_re, out_l_im  output  WIDTH  twiddled butterfly difference, scaled.

Behaviour:
- Reset (rst_n=1 at an edge):
  - All delay-line entries, the counter, the prime counter and all outputs go to 0.
  - Reset overrides in_valid/in_sof in the same cycle.
  - Reset mid-frame discards all in-flight data.
- The pipeline advances only on in_valid=1. With in_valid=0:
  - Delay lines and counters hold.
  - out_valid goes to 0 on the next edge.
  - Data outputs hold their last value.
- Sample counter cnt[2:0]:
  - Increments on each accepted sample and wraps 7->0.
  - An accepted sample with in_sof=1 is treated as cnt=0; the counter becomes 1 after it.
- Prime counter:
  - Saturating, 0..2*DEPTH. Increments per accepted sample.
  - Cleared by in_sof: the sof sample itself counts as 1.
- Datapath, per accepted sample:
  - Ld = in_l delayed DEPTH accepted samples.
  - Commutator, sel = cnt[2]:
    - sel=0: cU = in_up, cL = Ld.
    - sel=1: cU = Ld, cL = in_up.
  - Ud = cU delayed DEPTH accepted samples.
  - sum = Ud + cL and diff = Ud - cL, both WIDTH+1 bits, exact.
  - out_up = sum >>> 1, arithmetic (floor), truncated to WIDTH.
  - Twiddle k = cnt[1:0] of the current sample. ROM in Q1.7, 9-bit signed:
    - k0 = (128, 0)
    - k1 = (91, -91)
    - k2 = (0, -128)
    - k3 = (-91, -91)
  - Complex multiply: re = dr*wr - di*wi, im = dr*wi + di*wr, full precision.
  - out_l = product >>> 8 (1/2 scaling plus Q1.7 removal), floor, low WIDTH bits kept (wrap) unless the optional feature is enabled.
- Timing:
  - Outputs are registered: the result for an accepted sample appears on the following edge.
  - out_valid = registered (in_valid AND prime count was already 2*DEPTH before this sample).
  - The first 2*DEPTH samples after reset or sof produce out_valid=0.
- in_sof mid-frame: the counter resynchronises immediately. Delay-line contents are kept but treated as unprimed.

Optional Feature:
- Macro: FFT_STATE3_SAT_EN.
- Defined: out_up and out_l saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] whenever the shifted result exceeds WIDTH bits.
- Undefined: two's-complement wrap, i.e. the low WIDTH bits are kept.

Test Plan:
- Reset: drive random inputs with rst_n=1 for 3 cycles -> all outputs 0 and out_valid 0. Then rst_n=0 with 8 valid samples -> out_valid stays 0.
- DC: in_up_re = in_l_re = 10, im 0, continuous valid, sof on the first sample -> from the 9th output on, out_up_re = 10, out_l = (0,0).
- Twiddle sweep: in_up_re = 64 when cnt[2]=0, else 0; in_l = 0. On the second 8-group (samples 12..15), out_l per cycle = (32,0), (22,-23), (0,-32), (-23,-23) and out_up_re = 32.
- Stall: insert in_valid=0 bubbles every other cycle into the twiddle sweep -> identical valid output sequence; out_valid low during bubbles.
- Sof resync: assert in_sof at cnt=5 -> cnt restarts at 0 and out_valid is low for the next 8 accepted samples.
- Overflow: in_up_re = 511 in sel=0 blocks, in_l_re = -512, k0 -> out_l_re = 511 with FFT_STATE3_SAT_EN, and the wrapped low-10-bit value without it.
